adc_window_stats: RTL and testbench
===================================

Name: adc_window_stats

Overview:
- Sits directly downstream of the XADC single-channel wrapper; consumes its 12-bit sample stream (data/valid pulses).
- Groups samples into fixed windows of 2^LOG2_WINDOW samples and produces per-window mean, min, max and peak-to-peak amplitude for receiver signal-strength estimation.
- Result is offered on a valid/ready handshake to the downstream detection/display logic, with sticky overrun reporting when results are not consumed in time.

Parameters:
- LOG2_WINDOW, 8, log2 of samples per window (1..12); window N = 2^LOG2_WINDOW.
- DW, 12, sample width (matches XADC wrapper output).

Ports:
- clk  in  1  system clock, shared with XADC DRP clock.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  accumulation enable; low discards the partial window.
- data_i  in  DW  unsigned ADC sample.
- valid_i  in  1  single-cycle sample strobe; data_i sampled when high.
- clr_overrun_i  in  1  clears overrun_o.
- mean_o  out  DW  window mean = sum >> LOG2_WINDOW (truncating).
- min_o  out  DW  smallest sample in window.
- max_o  out  DW  largest sample in window.
- p2p_o  out  DW  max_o - min_o.
- valid_o  out  1  result available; held until accepted.
- ready_i  in  1  downstream accepts result when valid_o & ready_i.
- overrun_o  out  1  sticky: a completed window was dropped.

Behaviour:
- Reset (rst=1 at clk edge): valid_o=0, overrun_o=0, mean_o/min_o/max_o/p2p_o=0, sample counter=0, sum=0, running min=all-ones, running max=0. rst has priority over all other inputs.
- Sample accepted only when valid_i=1 and en_i=1. On accept: sum += data_i (sum width DW+LOG2_WINDOW, never overflows); running min/max updated; counter increments.
- First sample of a window (counter=0) loads sum/min/max directly from data_i instead of combining.
- Window completion: the accepted sample with counter=N-1. Counter wraps to 0; running state reinitialised the same cycle, so the next sample starts a new window with no gap.
- Result latency: outputs registered; valid_o rises on the clock edge following the completing sample (1-cycle latency). Result includes the completing sample.
- Handshake: valid_o stays high and outputs stay stable until valid_o & ready_i; valid_o drops the next cycle unless a new result loads at that same edge.
- Window completes while valid_o=1 and ready_i=1 at that edge: new result loads, valid_o stays 1, no overrun.
- Window completes while valid_o=1 and ready_i=0: new result dropped, old result retained, overrun_o set.
- overrun_o clears on clr_overrun_i=1; if a new overrun occurs the same cycle, set wins (stays 1).
- en_i low: counter and running state return to window-start values next edge; partial window discarded; pending output result and handshake unaffected.
- valid_i high with en_i low: sample ignored.
- Reset mid-window or with valid_o pending: all state discarded per reset values.
- p2p_o computed from the registered window min/max; always non-negative, no wrap.

Test Plan:
- LOG2_WINDOW=2, ready_i=1; samples 100,200,300,400 -> one cycle after 4th, valid_o=1, mean_o=250, min_o=100, max_o=400, p2p_o=300, overrun_o=0.
- LOG2_WINDOW=2; four samples of 0xFFF -> mean_o=4095, min_o=max_o=4095, p2p_o=0 (sum=16380, no overflow); then 0,0,0,3 -> mean_o=0, p2p_o=3.
- ready_i=0, two full windows (10,20,30,40 then 1,2,3,4) -> outputs hold mean_o=25, overrun_o=1; clr_overrun_i pulse -> overrun_o=0; ready_i=1 -> valid_o drops after one accept.
- ready_i asserted exactly on the cycle the second window completes -> first result consumed, second loaded (mean_o=2), valid_o stays 1, overrun_o=0.
- Samples 500,600, en_i low one cycle, then 7,7,7,11 -> single result mean_o=8, min_o=7, max_o=11; 500/600 excluded.
- rst asserted after 3 of 4 samples, then 4 samples of 50 -> one result mean_o=50, p2p_o=0; all outputs 0 and valid_o=0 during reset.

Source files
------------

// File: rtl/adc_window_stats.sv
// Windowed statistics over an unsigned ADC sample stream: per-window mean, min,
// max and peak-to-peak, offered on a valid/ready handshake with sticky overrun.
module adc_window_stats #(
   parameter int LOG2_WINDOW = 8,
   parameter int DW          = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic [DW-1:0] data_i,
   input  logic          valid_i,
   input  logic          clr_overrun_i,
   output logic [DW-1:0] mean_o,
   output logic [DW-1:0] min_o,
   output logic [DW-1:0] max_o,
   output logic [DW-1:0] p2p_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic          overrun_o
);

   localparam int SW = DW + LOG2_WINDOW;

   logic [LOG2_WINDOW-1:0] count_q, count_d;
   logic [SW-1:0]          sum_q, sum_d;
   logic [DW-1:0]          runMin_q, runMin_d;
   logic [DW-1:0]          runMax_q, runMax_d;
   logic [DW-1:0]          outMean_q, outMean_d;
   logic [DW-1:0]          outMin_q, outMin_d;
   logic [DW-1:0]          outMax_q, outMax_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;

   logic          accept;
   logic          firstSample;
   logic          lastSample;
   logic          loadResult;
   logic          dropResult;
   logic [SW-1:0] sampleSum;
   logic [DW-1:0] sampleMin;
   logic [DW-1:0] sampleMax;

   // Running statistics including the current sample; the first sample of a
   // window replaces the old state rather than combining with it.
   always_comb begin
      accept      = valid_i & en_i;
      firstSample = (count_q == '0);
      lastSample  = accept && (count_q == {LOG2_WINDOW{1'b1}});
      sampleSum   = firstSample ? {{LOG2_WINDOW{1'b0}}, data_i}
                                : sum_q + {{LOG2_WINDOW{1'b0}}, data_i};
      sampleMin   = (firstSample || (data_i < runMin_q)) ? data_i : runMin_q;
      sampleMax   = (firstSample || (data_i > runMax_q)) ? data_i : runMax_q;
      loadResult  = lastSample && (!valid_q || ready_i);
      dropResult  = lastSample && valid_q && !ready_i;
   end

   always_comb begin
      count_d  = count_q;
      sum_d    = sum_q;
      runMin_d = runMin_q;
      runMax_d = runMax_q;
      if (!en_i || lastSample) begin
         count_d  = '0;
         sum_d    = '0;
         runMin_d = '1;
         runMax_d = '0;
      end else if (accept) begin
         count_d  = count_q + 1'b1;
         sum_d    = sampleSum;
         runMin_d = sampleMin;
         runMax_d = sampleMax;
      end
   end

   // A completed window only replaces the result if the old one is gone or
   // being taken this very edge; otherwise it is dropped and flagged.
   always_comb begin
      outMean_d = outMean_q;
      outMin_d  = outMin_q;
      outMax_d  = outMax_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (loadResult) begin
         outMean_d = sampleSum[SW-1:LOG2_WINDOW];
         outMin_d  = sampleMin;
         outMax_d  = sampleMax;
         valid_d   = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (dropResult) begin
         overrun_d = 1'b1;
      end else if (clr_overrun_i) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         sum_q     <= '0;
         runMin_q  <= '1;
         runMax_q  <= '0;
         outMean_q <= '0;
         outMin_q  <= '0;
         outMax_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         sum_q     <= sum_d;
         runMin_q  <= runMin_d;
         runMax_q  <= runMax_d;
         outMean_q <= outMean_d;
         outMin_q  <= outMin_d;
         outMax_q  <= outMax_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign mean_o    = outMean_q;
   assign min_o     = outMin_q;
   assign max_o     = outMax_q;
   assign p2p_o     = outMax_q - outMin_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_adc_window_stats.sv
// Directed, table-driven bench for adc_window_stats with a 4-sample window;
// every vector is one clock edge followed by a full output comparison.
module tb_adc_window_stats;

   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          enI;
   logic [DW-1:0] dataI;
   logic          validI;
   logic          clrI;
   logic          readyI;
   logic [DW-1:0] meanO, minO, maxO, p2pO;
   logic          validO, overrunO;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      string         name;
      logic          rst, en, valid;
      logic [DW-1:0] data;
      logic          ready, clr;
      logic          expValid;
      logic [DW-1:0] expMean, expMin, expMax, expP2p;
      logic          expOverrun;
   } vec_t;

   vec_t vecs[$];

   adc_window_stats #(.LOG2_WINDOW(2), .DW(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .en_i          (enI),
      .data_i        (dataI),
      .valid_i       (validI),
      .clr_overrun_i (clrI),
      .mean_o        (meanO),
      .min_o         (minO),
      .max_o         (maxO),
      .p2p_o         (p2pO),
      .valid_o       (validO),
      .ready_i       (readyI),
      .overrun_o     (overrunO)
   );

   always #5 clk = ~clk;

   function automatic void add(string n, logic r, logic e, logic v, int d,
                               logic rd, logic c, logic ev, int em, int emin,
                               int emax, int ep, logic eo);
      vec_t t;
      t.name = n; t.rst = r; t.en = e; t.valid = v; t.data = DW'(d);
      t.ready = rd; t.clr = c; t.expValid = ev; t.expMean = DW'(em);
      t.expMin = DW'(emin); t.expMax = DW'(emax); t.expP2p = DW'(ep);
      t.expOverrun = eo;
      vecs.push_back(t);
   endfunction

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic r, input logic e, input logic v,
                                input logic [DW-1:0] d, input logic rd,
                                input logic c);
      rst = r; enI = e; validI = v; dataI = d; readyI = rd; clrI = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string n, input logic ev,
                              input logic [DW-1:0] em, input logic [DW-1:0] emin,
                              input logic [DW-1:0] emax, input logic [DW-1:0] ep,
                              input logic eo);
      vecCount++;
      if (validO !== ev || meanO !== em || minO !== emin || maxO !== emax ||
          p2pO !== ep || overrunO !== eo) begin
         missCount++;
         $display("[TB] FAIL %s: got v=%0d mean=%0d min=%0d max=%0d p2p=%0d ov=%0d, want v=%0d mean=%0d min=%0d max=%0d p2p=%0d ov=%0d",
                  n, validO, meanO, minO, maxO, p2pO, overrunO,
                  ev, em, emin, emax, ep, eo);
      end
   endtask

   initial begin
      int waitCycles;
      rst = 1'b1; enI = 1'b0; validI = 1'b0; dataI = '0; readyI = 1'b0; clrI = 1'b0;

      //   name           rst en vl data rdy clr  ev mean  min   max   p2p ov
      add("reset",        1, 0, 0,   0, 1, 0,   0,    0,    0,    0,    0, 0);
      add("w1 s0",        0, 1, 1, 100, 1, 0,   0,    0,    0,    0,    0, 0);
      add("w1 s1",        0, 1, 1, 200, 1, 0,   0,    0,    0,    0,    0, 0);
      add("w1 s2",        0, 1, 1, 300, 1, 0,   0,    0,    0,    0,    0, 0);
      add("w1 done",      0, 1, 1, 400, 1, 0,   1,  250,  100,  400,  300, 0);
      add("w1 taken",     0, 1, 0,   0, 1, 0,   0,  250,  100,  400,  300, 0);
      add("fff s0",       0, 1, 1, 4095, 1, 0,  0,  250,  100,  400,  300, 0);
      add("fff s1",       0, 1, 1, 4095, 1, 0,  0,  250,  100,  400,  300, 0);
      add("fff s2",       0, 1, 1, 4095, 1, 0,  0,  250,  100,  400,  300, 0);
      add("fff done",     0, 1, 1, 4095, 1, 0,  1, 4095, 4095, 4095,    0, 0);
      add("zero s0",      0, 1, 1,   0, 1, 0,   0, 4095, 4095, 4095,    0, 0);
      add("zero s1",      0, 1, 1,   0, 1, 0,   0, 4095, 4095, 4095,    0, 0);
      add("zero s2",      0, 1, 1,   0, 1, 0,   0, 4095, 4095, 4095,    0, 0);
      add("zero done",    0, 1, 1,   3, 1, 0,   1,    0,    0,    3,    3, 0);
      add("zero taken",   0, 1, 0,   0, 1, 0,   0,    0,    0,    3,    3, 0);
      add("ov a0",        0, 1, 1,  10, 0, 0,   0,    0,    0,    3,    3, 0);
      add("ov a1",        0, 1, 1,  20, 0, 0,   0,    0,    0,    3,    3, 0);
      add("ov a2",        0, 1, 1,  30, 0, 0,   0,    0,    0,    3,    3, 0);
      add("ov a done",    0, 1, 1,  40, 0, 0,   1,   25,   10,   40,   30, 0);
      add("ov b0",        0, 1, 1,   1, 0, 0,   1,   25,   10,   40,   30, 0);
      add("ov b1",        0, 1, 1,   2, 0, 0,   1,   25,   10,   40,   30, 0);
      add("ov b2",        0, 1, 1,   3, 0, 0,   1,   25,   10,   40,   30, 0);
      add("ov b drop",    0, 1, 1,   4, 0, 0,   1,   25,   10,   40,   30, 1);
      add("ov clear",     0, 1, 0,   0, 0, 1,   1,   25,   10,   40,   30, 0);
      add("ov taken",     0, 1, 0,   0, 1, 0,   0,   25,   10,   40,   30, 0);
      add("bb a0",        0, 1, 1,  10, 0, 0,   0,   25,   10,   40,   30, 0);
      add("bb a1",        0, 1, 1,  20, 0, 0,   0,   25,   10,   40,   30, 0);
      add("bb a2",        0, 1, 1,  30, 0, 0,   0,   25,   10,   40,   30, 0);
      add("bb a done",    0, 1, 1,  40, 0, 0,   1,   25,   10,   40,   30, 0);
      add("bb b0",        0, 1, 1,   1, 0, 0,   1,   25,   10,   40,   30, 0);
      add("bb b1",        0, 1, 1,   2, 0, 0,   1,   25,   10,   40,   30, 0);
      add("bb b2",        0, 1, 1,   3, 0, 0,   1,   25,   10,   40,   30, 0);
      add("bb swap",      0, 1, 1,   4, 1, 0,   1,    2,    1,    4,    3, 0);
      add("bb taken",     0, 1, 0,   0, 1, 0,   0,    2,    1,    4,    3, 0);
      add("en s0",        0, 1, 1, 500, 1, 0,   0,    2,    1,    4,    3, 0);
      add("en s1",        0, 1, 1, 600, 1, 0,   0,    2,    1,    4,    3, 0);
      add("en low",       0, 0, 1, 999, 1, 0,   0,    2,    1,    4,    3, 0);
      add("en 7a",        0, 1, 1,   7, 1, 0,   0,    2,    1,    4,    3, 0);
      add("en 7b",        0, 1, 1,   7, 1, 0,   0,    2,    1,    4,    3, 0);
      add("en 7c",        0, 1, 1,   7, 1, 0,   0,    2,    1,    4,    3, 0);
      add("en done",      0, 1, 1,  11, 1, 0,   1,    8,    7,   11,    4, 0);
      add("en taken",     0, 1, 0,   0, 1, 0,   0,    8,    7,   11,    4, 0);
      add("rst p0",       0, 1, 1,  50, 1, 0,   0,    8,    7,   11,    4, 0);
      add("rst p1",       0, 1, 1,  50, 1, 0,   0,    8,    7,   11,    4, 0);
      add("rst p2",       0, 1, 1,  50, 1, 0,   0,    8,    7,   11,    4, 0);
      add("rst mid",      1, 1, 1,  50, 1, 0,   0,    0,    0,    0,    0, 0);
      add("rst s0",       0, 1, 1,  50, 1, 0,   0,    0,    0,    0,    0, 0);
      add("rst s1",       0, 1, 1,  50, 1, 0,   0,    0,    0,    0,    0, 0);
      add("rst s2",       0, 1, 1,  50, 1, 0,   0,    0,    0,    0,    0, 0);
      add("rst done",     0, 1, 1,  50, 0, 0,   1,   50,   50,   50,    0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].data,
                       vecs[i].ready, vecs[i].clr);
         checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expMean,
                     vecs[i].expMin, vecs[i].expMax, vecs[i].expP2p,
                     vecs[i].expOverrun);
      end

      // Overrun set and clear in the same cycle: set must win.
      applyStimulus(0, 1, 1, 1, 0, 0);
      applyStimulus(0, 1, 1, 2, 0, 0);
      applyStimulus(0, 1, 1, 3, 0, 0);
      applyStimulus(0, 1, 1, 4, 0, 1);
      checkOutput("set beats clr", 1, 50, 50, 50, 0, 1);

      // Reset with a result pending and overrun set wipes everything.
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("rst pending", 0, 0, 0, 0, 0, 0);

      // Fresh window after reset: valid_o must rise right after the 4th sample.
      waitCycles = 0;
      do begin
         applyStimulus(0, 1, 1, DW'(8 + 4 * waitCycles), 1, 0);
         waitCycles++;
      end while (validO !== 1'b1 && waitCycles < 10);
      vecCount++;
      if (waitCycles != 4) begin
         missCount++;
         $display("[TB] FAIL post-reset latency: valid after %0d samples, want 4", waitCycles);
      end
      checkOutput("post-reset win", 1, 14, 8, 20, 12, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
